// File: rtl/if_fetch_unit_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package if_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;

    typedef enum logic {
        FETCH = 1'b0,
        READY = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit.sv
// IF stage: one outstanding fetch, nop bubble until memory answers, MIPS delay-slot redirects.
// A fetched instruction is held in READY until stall drops; the next request issues the cycle after.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic [31:0] if_instr,
    output logic        if_valid
);

    fetch_state_t state, state_next;
    logic [31:0]  pc_q;
    logic [31:0]  instr_q;
    logic         pend_v;
    logic [31:0]  pend_pc;

    logic [31:0]  redirect_target;
    logic [31:0]  next_pc;
    logic         handover;

    assign redirect_target = redirect_pc & WORD_MASK;
    assign handover        = (state == READY) && !stall;

    always_comb begin
        next_pc = pc_q + PC_STEP;
        if (redirect_valid) begin
            next_pc = redirect_target;
        end else if (pend_v) begin
            next_pc = pend_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Memory data is captured even under stall; stall only holds the READY instruction.
    always_comb begin
        state_next = state;
        case (state)
            FETCH: begin
                if (im_rvalid) begin
                    state_next = READY;
                end
            end
            READY: begin
                if (!stall) begin
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pend_v  <= 1'b0;
            pend_pc <= 32'h0;
        end else begin
            if (state == FETCH && im_rvalid) begin
                instr_q <= im_rdata;
            end
            if (handover) begin
                pc_q   <= next_pc;
                pend_v <= 1'b0;
            end else if (redirect_valid) begin
                // Newest target wins; applied after the delay slot is handed over.
                pend_v  <= 1'b1;
                pend_pc <= redirect_target;
            end
        end
    end

    assign if_pc    = pc_q;
    assign if_pc4   = pc_q + PC_STEP;
    assign if_valid = (state == READY);
    assign if_instr = if_valid ? instr_q : NOP_INSTR;
    assign im_req   = (state == FETCH);
    assign im_addr  = pc_q & WORD_MASK;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed vector bench for if_fetch_unit: per-cycle stimulus table plus reset/wrap sequences.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_rvalid;
    logic [31:0] im_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic [31:0] if_instr;
    logic        if_valid;

    int errors = 0;
    int checks = 0;

    if_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .im_req         (im_req),
        .im_addr        (im_addr),
        .im_rvalid      (im_rvalid),
        .im_rdata       (im_rdata),
        .if_pc          (if_pc),
        .if_pc4         (if_pc4),
        .if_instr       (if_instr),
        .if_valid       (if_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        rvalid;
        logic [31:0] rdata;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        req;
        logic [31:0] addr;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic st, input logic rv, input logic [31:0] rpc,
                                input logic rvl, input logic [31:0] rd,
                                input logic [31:0] pc, input logic [31:0] ins,
                                input logic vl, input logic rq, input logic [31:0] ad);
        vec_t v;
        v.stall = st;  v.rv = rv;      v.rpc = rpc;  v.rvalid = rvl; v.rdata = rd;
        v.pc = pc;     v.instr = ins;  v.valid = vl; v.req = rq;     v.addr = ad;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic [31:0] pc, input logic [31:0] ins,
                           input logic vl, input logic rq, input logic [31:0] ad);
        chk("if_pc",    idx, if_pc,    pc);
        chk("if_pc4",   idx, if_pc4,   pc + 32'd4);
        chk("if_instr", idx, if_instr, ins);
        chk("if_valid", idx, {31'd0, if_valid}, {31'd0, vl});
        chk("im_req",   idx, {31'd0, im_req},   {31'd0, rq});
        chk("im_addr",  idx, im_addr,  ad);
    endtask

    task automatic drive(input logic st, input logic rv, input logic [31:0] rpc,
                         input logic rvl, input logic [31:0] rd);
        stall = st; redirect_valid = rv; redirect_pc = rpc; im_rvalid = rvl; im_rdata = rd;
    endtask

    initial begin
        //              stall rv rpc           rvl rdata         pc            instr         vl rq addr
        vecs[0]  = mk(0, 0, 32'h0,        1, 32'hA000_0000, 32'h3000, 32'h0,        0, 1, 32'h3000);
        vecs[1]  = mk(0, 0, 32'h0,        0, 32'h0,         32'h3000, 32'hA000_0000, 1, 0, 32'h3000);
        vecs[2]  = mk(0, 0, 32'h0,        1, 32'hA000_0001, 32'h3004, 32'h0,        0, 1, 32'h3004);
        vecs[3]  = mk(0, 0, 32'h0,        0, 32'h0,         32'h3004, 32'hA000_0001, 1, 0, 32'h3004);
        // redirect while 0x3008 is in flight: 0x3008 remains the delay slot
        vecs[4]  = mk(0, 1, 32'h3100,     0, 32'h0,         32'h3008, 32'h0,        0, 1, 32'h3008);
        vecs[5]  = mk(0, 0, 32'h0,        1, 32'hA000_0002, 32'h3008, 32'h0,        0, 1, 32'h3008);
        vecs[6]  = mk(0, 0, 32'h0,        0, 32'h0,         32'h3008, 32'hA000_0002, 1, 0, 32'h3008);
        // 4-cycle memory latency at the redirect target
        vecs[7]  = mk(0, 0, 32'h0,        0, 32'h0,         32'h3100, 32'h0,        0, 1, 32'h3100);
        vecs[8]  = mk(0, 0, 32'h0,        0, 32'h0,         32'h3100, 32'h0,        0, 1, 32'h3100);
        vecs[9]  = mk(0, 0, 32'h0,        0, 32'h0,         32'h3100, 32'h0,        0, 1, 32'h3100);
        vecs[10] = mk(0, 0, 32'h0,        1, 32'hA000_0003, 32'h3100, 32'h0,        0, 1, 32'h3100);
        // READY under stall, two redirects: newest wins, low bits dropped
        vecs[11] = mk(1, 0, 32'h0,        0, 32'h0,         32'h3100, 32'hA000_0003, 1, 0, 32'h3100);
        vecs[12] = mk(1, 1, 32'h3200,     0, 32'h0,         32'h3100, 32'hA000_0003, 1, 0, 32'h3100);
        vecs[13] = mk(1, 1, 32'h3303,     0, 32'h0,         32'h3100, 32'hA000_0003, 1, 0, 32'h3100);
        vecs[14] = mk(0, 0, 32'h0,        0, 32'h0,         32'h3100, 32'hA000_0003, 1, 0, 32'h3100);
        vecs[15] = mk(0, 0, 32'h0,        1, 32'hA000_0004, 32'h3300, 32'h0,        0, 1, 32'h3300);
        // redirect coincident with handover is used directly
        vecs[16] = mk(0, 1, 32'h3404,     0, 32'h0,         32'h3300, 32'hA000_0004, 1, 0, 32'h3300);
        vecs[17] = mk(0, 0, 32'h0,        1, 32'hA000_0005, 32'h3404, 32'h0,        0, 1, 32'h3404);
        vecs[18] = mk(0, 0, 32'h0,        0, 32'h0,         32'h3404, 32'hA000_0005, 1, 0, 32'h3404);
        // data arriving under stall is still captured; release steps to pc+4
        vecs[19] = mk(1, 0, 32'h0,        1, 32'hA000_0006, 32'h3408, 32'h0,        0, 1, 32'h3408);
        vecs[20] = mk(1, 0, 32'h0,        0, 32'h0,         32'h3408, 32'hA000_0006, 1, 0, 32'h3408);
        vecs[21] = mk(0, 0, 32'h0,        0, 32'h0,         32'h3408, 32'hA000_0006, 1, 0, 32'h3408);
        vecs[22] = mk(0, 0, 32'h0,        1, 32'hA000_0007, 32'h340C, 32'h0,        0, 1, 32'h340C);

        reset = 1'b1;
        drive(0, 0, 32'h0, 0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i].stall, vecs[i].rv, vecs[i].rpc, vecs[i].rvalid, vecs[i].rdata);
            #1;
            chk_all(i, vecs[i].pc, vecs[i].instr, vecs[i].valid, vecs[i].req, vecs[i].addr);
        end

        // READY at 0x340C with a pending redirect, then reset discards everything
        @(negedge clk);
        drive(1, 1, 32'h3500, 0, 32'h0);
        #1 chk_all(100, 32'h340C, 32'hA000_0007, 1, 0, 32'h340C);
        @(negedge clk);
        reset = 1'b1;
        drive(1, 0, 32'h0, 0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 32'h0, 1, 32'hB000_0000);
        #1 chk_all(101, 32'h3000, 32'h0, 0, 1, 32'h3000);
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 32'h0);
        #1 chk_all(102, 32'h3000, 32'hB000_0000, 1, 0, 32'h3000);
        @(negedge clk);
        drive(0, 1, 32'hFFFF_FFFF, 0, 32'h0);
        #1 chk_all(103, 32'h3004, 32'h0, 0, 1, 32'h3004);

        // PC wrap: pc4 of 0xFFFFFFFC is 0
        @(negedge clk);
        drive(0, 0, 32'h0, 1, 32'hB000_0001);
        #1 chk_all(104, 32'h3004, 32'h0, 0, 1, 32'h3004);
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 32'h0);
        #1 chk_all(105, 32'h3004, 32'hB000_0001, 1, 0, 32'h3004);
        @(negedge clk);
        #1 chk_all(106, 32'hFFFF_FFFC, 32'h0, 0, 1, 32'hFFFF_FFFC);
        chk("if_pc4_wrap", 106, if_pc4, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
